prbs31_checker: RTL

Serial PRBS31 receiver/checker, the far end of the team's PRBS31 generator (polynomial x^31 + x^28 + 1, generator output taken from its MSB).
- Self-synchronises to an incoming bit stream, declares lock, then counts bit errors against a locally predicted sequence.
- Drops lock on excessive error density and re-hunts.
- Sits in the TinyTapeout top beside the generator; a board loopback from generator output to checker input gives a BER test.

---
 rtl/prbs31_pkg.sv | 27 ++
 rtl/prbs31_err_window.sv | 54 +++++
 rtl/prbs31_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/prbs31_pkg.sv
// Shared constants and types for the PRBS31 (x^31 + x^28 + 1) generator and checker.
// Tap positions index a shift register whose bit 0 holds the newest bit.
package prbs31_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 27;
    localparam int TAP_B    = 30;

    localparam int LOCK_CNT_DEF = 64;
    localparam int WIN_LEN_DEF  = 1024;
    localparam int LOSS_THR_DEF = 8;
    localparam int CNT_W_DEF    = 16;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int FILL_W = cnt_w(PRBS_LEN - 1);

endpackage

// File: rtl/prbs31_err_window.sv
// Sliding-block error density monitor: counts errors per WIN_LEN qualified bits and
// requests loss of lock when LOSS_THR errors land inside one window.
module prbs31_err_window
    import prbs31_pkg::*;
#(
    parameter int WIN_LEN  = WIN_LEN_DEF,
    parameter int LOSS_THR = LOSS_THR_DEF
) (
    input  logic clk,
    input  logic rst_i,
    input  logic bit_en_i,
    input  logic err_en_i,
    input  logic restart_i,
    output logic loss_req_o
);

    localparam int BIT_W = cnt_w(WIN_LEN - 1);
    localparam int ERR_W = cnt_w(LOSS_THR);

    logic [BIT_W-1:0] win_bit_q, win_bit_d;
    logic [ERR_W-1:0] win_err_q, win_err_d;
    logic             win_end;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which is what keeps combinational blocks free of latches.
    always_comb begin
        win_end    = bit_en_i && (win_bit_q == BIT_W'(WIN_LEN - 1));
        loss_req_o = bit_en_i && err_en_i && (win_err_q == ERR_W'(LOSS_THR - 1));
        win_bit_d  = win_bit_q;
        win_err_d  = win_err_q;
        if (restart_i || win_end || loss_req_o) begin
            win_bit_d = '0;
            win_err_d = '0;
        end else if (bit_en_i) begin
            win_bit_d = win_bit_q + BIT_W'(1);
            if (err_en_i) begin
                win_err_d = win_err_q + ERR_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            win_bit_q <= '0;
            win_err_q <= '0;
        end else begin
            win_bit_q <= win_bit_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// Serial PRBS31 checker: hunts for the sequence, verifies it, then flywheels on its
// own prediction while counting bit errors and watching error density.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int WIN_LEN  = WIN_LEN_DEF,
    parameter int LOSS_THR = LOSS_THR_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             lost_lock
);

    localparam int MATCH_W = cnt_w(LOCK_CNT);

    state_e              state_q, state_d;
    logic [PRBS_LEN-1:0] sr_q, sr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                lost_lock_q, lost_lock_d;

    logic predicted, mismatch, bit_en, err_hit, loss_req;

    assign predicted = sr_q[TAP_A] ^ sr_q[TAP_B];
    assign mismatch  = din ^ predicted;
    assign bit_en    = din_valid && (state_q == LOCKED);
    assign err_hit   = bit_en && mismatch;

    // Window counters are held at zero outside LOCKED, so each lock starts a fresh window.
    prbs31_err_window #(
        .WIN_LEN  (WIN_LEN),
        .LOSS_THR (LOSS_THR)
    ) u_err_window (
        .clk        (clk),
        .rst_i      (rst_n),
        .bit_en_i   (bit_en),
        .err_en_i   (mismatch),
        .restart_i  (state_q != LOCKED),
        .loss_req_o (loss_req)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    sr_d = {sr_q[PRBS_LEN-2:0], din};
                    if (fill_q == FILL_W'(PRBS_LEN - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[PRBS_LEN-2:0], din};
                    // An all-zero register predicts zeros forever; never trust it.
                    if (!mismatch && (sr_q != '0)) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    sr_d = {sr_q[PRBS_LEN-2:0], predicted};
                    if (loss_req) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d    = (state_d == LOCKED);
        err_pulse_d = err_hit;

        if (clear) begin
            err_count_d = err_hit ? CNT_W'(1) : '0;
        end else if (err_hit && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end

        lost_lock_d = loss_req ? 1'b1 : (clear ? 1'b0 : lost_lock_q);
    end

    // NOTE: rst_n is active-high despite its name; every register, including the
    // shift register, is reset so a mid-run reset leaves no stale alignment behind.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            lost_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign lost_lock = lost_lock_q;

endmodule
